// File: rtl/lenet_pkg.sv
// Shared LeNet layer definitions: feature-map sides, layer-mode encodings,
// the mode-to-side decode used by both the line buffer and the pixel streamer.
package lenet_pkg;

  localparam int FM1_SIZE = 32;
  localparam int FM2_SIZE = 28;
  localparam int FM3_SIZE = 14;
  localparam int FM4_SIZE = 10;
  localparam int FM5_SIZE = 5;

  localparam logic [2:0] MODE_C1     = 3'b000;
  localparam logic [2:0] MODE_S2     = 3'b001;
  localparam logic [2:0] MODE_C3     = 3'b010;
  localparam logic [2:0] MODE_S4     = 3'b011;
  localparam logic [2:0] MODE_C5     = 3'b100;
  localparam logic [2:0] MODE_S2_ALT = 3'b101;
  localparam logic [2:0] MODE_F6     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } stream_state_e;

  // Unlisted encodings (111) fall back to the full 32x32 input map.
  function automatic int width_of_mode(input logic [2:0] mode,
                                       input int s1, input int s2, input int s3,
                                       input int s4, input int s5);
    case (mode)
      MODE_S2, MODE_S2_ALT: return s2;
      MODE_C3:              return s3;
      MODE_S4, MODE_F6:     return s4;
      MODE_C5:              return s5;
      default:              return s1;
    endcase
  endfunction

endpackage

// File: rtl/fmap_raster_counter.sv
// Row-major raster counter: row/col wrap at side, running linear address,
// and a flag marking the last pixel of the square frame.
module fmap_raster_counter #(
  parameter int ADDR_WIDTH = 10,
  parameter int RC_W       = 5,
  parameter int SIDE_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  adv,
  input  logic [SIDE_W-1:0]     side,
  output logic [RC_W-1:0]       row,
  output logic [RC_W-1:0]       col,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [SIDE_W-1:0] side_m1;
  logic              col_end;
  logic              row_end;

  assign side_m1 = side - SIDE_W'(1);
  assign col_end = (SIDE_W'(col) == side_m1);
  assign row_end = (SIDE_W'(row) == side_m1);
  assign last    = col_end && row_end;

  // Address is a running count so no row*side multiplier is needed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (adv) begin
      addr <= addr + ADDR_WIDTH'(1);
      if (col_end) begin
        col <= '0;
        row <= row + RC_W'(1);
      end else begin
        col <= col + RC_W'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_pixel_streamer.sv
// Streams one square feature map from a synchronous-read RAM into the line
// buffer, row-major and gap-free, with row/col tags and a window-complete flag.
module fmap_pixel_streamer
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 10,
  parameter int MAX_WIDTH         = 32,
  parameter int FEATURE_MAP1_SIZE = FM1_SIZE,
  parameter int FEATURE_MAP2_SIZE = FM2_SIZE,
  parameter int FEATURE_MAP3_SIZE = FM3_SIZE,
  parameter int FEATURE_MAP4_SIZE = FM4_SIZE,
  parameter int FEATURE_MAP5_SIZE = FM5_SIZE,
  parameter int KERNEL_SIZE       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   mode,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [DATA_WIDTH-1:0]        pix_out,
  output logic                         pix_valid,
  output logic [$clog2(MAX_WIDTH)-1:0] pix_row,
  output logic [$clog2(MAX_WIDTH)-1:0] pix_col,
  output logic                         win_ok
);

  localparam int RC_W   = $clog2(MAX_WIDTH);
  localparam int SIDE_W = $clog2(MAX_WIDTH + 1);
  localparam logic [RC_W-1:0] K_LAST = RC_W'(KERNEL_SIZE - 1);

  stream_state_e     state;
  logic [SIDE_W-1:0] side;
  logic [RC_W-1:0]   cnt_row;
  logic [RC_W-1:0]   cnt_col;
  logic              cnt_last;
  logic              cnt_clear;
  logic              cnt_adv;
  logic              vld_p1;
  logic [RC_W-1:0]   row_p1;
  logic [RC_W-1:0]   col_p1;

  assign cnt_clear = (state == ST_IDLE) && start;
  assign cnt_adv   = (state == ST_ISSUE) && !cnt_last;

  fmap_raster_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RC_W      (RC_W),
    .SIDE_W    (SIDE_W)
  ) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .adv  (cnt_adv),
    .side (side),
    .row  (cnt_row),
    .col  (cnt_col),
    .addr (mem_addr),
    .last (cnt_last)
  );

  // Stage p1: tags aligned with the RAM read data.
  always_ff @(posedge clk) begin
    row_p1 <= cnt_row;
    col_p1 <= cnt_col;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      side      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      vld_p1    <= 1'b0;
      pix_valid <= 1'b0;
      pix_out   <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      win_ok    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ISSUE;
            side      <= SIDE_W'(width_of_mode(mode, FEATURE_MAP1_SIZE, FEATURE_MAP2_SIZE,
                                               FEATURE_MAP3_SIZE, FEATURE_MAP4_SIZE,
                                               FEATURE_MAP5_SIZE));
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (cnt_last) begin
            state     <= ST_DRAIN;
            mem_rd_en <= 1'b0;
          end
        end
        ST_DRAIN: state <= ST_FIN;
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      vld_p1 <= mem_rd_en;
      // Stage p2: registered pixel and tags presented to the line buffer.
      pix_valid <= vld_p1;
      pix_out   <= vld_p1 ? mem_rd_data : '0;
      pix_row   <= vld_p1 ? row_p1 : '0;
      pix_col   <= vld_p1 ? col_p1 : '0;
      win_ok    <= vld_p1 && (row_p1 >= K_LAST) && (col_p1 >= K_LAST);
    end
  end

endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// Bench for fmap_pixel_streamer: RAM model, frame-timeline reference model,
// per-cycle comparison and hand-computed frame totals.
module tb_fmap_pixel_streamer;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic [4:0] pix_row;
  logic [4:0] pix_col;
  logic       win_ok;

  logic [7:0] ram [1024];

  int n_pass = 0;
  int n_total = 0;
  bit armed = 0;
  bit m_active = 0;
  int m_j = 0;
  int m_n = 0;
  int m_w = 0;
  int tot_valid = 0;
  int tot_win = 0;
  int tot_done = 0;
  int last_done_j = -1;
  int s_valid, s_win, s_done;

  fmap_pixel_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .win_ok     (win_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  function automatic int side_of(input logic [2:0] m);
    case (m)
      3'd1, 3'd5: return 28;
      3'd2:       return 14;
      3'd3, 3'd6: return 10;
      3'd4:       return 5;
      default:    return 32;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outputs at offset j cycles after the accepting edge:
  // reads for j<N, pixels for 2<=j<N+2, done at j=N+2.
  task automatic cmp_cycle();
    int e_rd, e_addr, e_busy, e_done, e_vld, e_pix, e_row, e_col, e_win, k;
    e_rd = 0; e_addr = 0; e_busy = 0; e_done = 0; e_vld = 0;
    e_pix = 0; e_row = 0; e_col = 0; e_win = 0;
    if (m_active) begin
      e_rd   = (m_j < m_n) ? 1 : 0;
      e_addr = (m_j < m_n) ? m_j : m_n - 1;
      e_busy = (m_j < m_n + 2) ? 1 : 0;
      e_done = (m_j == m_n + 2) ? 1 : 0;
      if (m_j >= 2 && m_j < m_n + 2) begin
        k = m_j - 2;
        e_vld = 1;
        e_pix = int'(ram[k]);
        e_row = k / m_w;
        e_col = k % m_w;
        e_win = (e_row >= 4 && e_col >= 4) ? 1 : 0;
      end
    end
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("mem_rd_en", int'(mem_rd_en), e_rd);
    chk("mem_addr", int'(mem_addr), e_addr);
    chk("pix_valid", int'(pix_valid), e_vld);
    chk("pix_out", int'(pix_out), e_pix);
    chk("pix_row", int'(pix_row), e_row);
    chk("pix_col", int'(pix_col), e_col);
    chk("win_ok", int'(win_ok), e_win);
    if (pix_valid) tot_valid++;
    if (win_ok) tot_win++;
    if (done) begin
      tot_done++;
      last_done_j = m_j;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    s_valid = tot_valid;
    s_win   = tot_win;
    s_done  = tot_done;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 1024; i++) ram[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic start_frame(input logic [2:0] md);
    step();
    mode  = md;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int e_valid, input int e_win, input int e_dj);
    for (int i = 0; i < 1200 && m_j < m_n + 2; i++) step();
    chk({tag, "_timeout"}, (m_j >= m_n + 2) ? 1 : 0, 1);
    chk({tag, "_valid_cnt"}, tot_valid - s_valid, e_valid);
    chk({tag, "_win_cnt"}, tot_win - s_win, e_win);
    chk({tag, "_done_cnt"}, tot_done - s_done, 1);
    chk({tag, "_done_cycle"}, last_done_j, e_dj);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 3'd0;
    fill(1'b0);

    fork
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          m_active = 0;
          armed = 1;
        end else if ((!m_active || m_j >= m_n + 2) && start) begin
          m_active = 1;
          m_j = 0;
          m_w = side_of(mode);
          m_n = m_w * m_w;
        end else if (m_active) begin
          m_j++;
        end
      end
      forever begin
        @(negedge clk);
        if (armed) cmp_cycle();
      end
    join_none

    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    rst_n = 1'b1;
    step();

    // 5x5 frame with RAM[k]=k, spurious starts in ISSUE and FIN.
    snap();
    start_frame(3'd4);
    chk("A_addr0", int'(mem_addr), 0);
    chk("A_rden0", int'(mem_rd_en), 1);
    for (int i = 0; i < 100 && m_j < 27; i++) begin
      start = (m_j == 10 || m_j == 26);
      if (m_j == 2) begin
        chk("A_first_pix", int'(pix_out), 0);
        chk("A_first_vld", int'(pix_valid), 1);
      end
      if (m_j == 26) begin
        chk("A_last_pix", int'(pix_out), 24);
        chk("A_last_row", int'(pix_row), 4);
        chk("A_last_col", int'(pix_col), 4);
        chk("A_last_win", int'(win_ok), 1);
      end
      step();
    end
    start = 1'b0;
    chk("A_valid_cnt", tot_valid - s_valid, 25);
    chk("A_win_cnt", tot_win - s_win, 1);
    chk("A_done_cnt", tot_done - s_done, 1);
    chk("A_done_cycle", last_done_j, 27);
    chk("A_done_now", int'(done), 1);
    chk("A_busy_at_done", int'(busy), 0);

    // Start in the done cycle launches the next frame immediately.
    snap();
    mode  = 3'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("A2_addr0", int'(mem_addr), 0);
    chk("A2_rden0", int'(mem_rd_en), 1);
    chk("A2_busy", int'(busy), 1);
    wait_end("A2", 25, 1, 27);

    snap();
    start_frame(3'd0);
    wait_end("B", 1024, 784, 1026);

    // Mode switched mid-frame must not change the latched side.
    fill(1'b1);
    snap();
    start_frame(3'd2);
    for (int i = 0; i < 100 && m_j < 52; i++) step();
    mode = 3'd0;
    wait_end("C", 196, 100, 198);

    // Randomized frames with random mode toggling and starts while busy.
    for (int f = 0; f < 4; f++) begin
      logic [2:0] md;
      int sd;
      md = 3'($urandom_range(0, 7));
      sd = side_of(md);
      fill(1'b1);
      snap();
      start_frame(md);
      for (int i = 0; i < 1200 && m_j < m_n + 2; i++) begin
        start = ($urandom_range(0, 7) == 0) && (m_j <= m_n + 1);
        mode  = 3'($urandom);
        step();
      end
      start = 1'b0;
      chk("D_valid_cnt", tot_valid - s_valid, sd * sd);
      chk("D_done_cnt", tot_done - s_done, 1);
    end

    // Reset at pixel 300 of a 28x28 frame aborts it without done.
    fill(1'b1);
    start_frame(3'd1);
    for (int i = 0; i < 400 && m_j < 302; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("E_busy", int'(busy), 0);
    chk("E_rden", int'(mem_rd_en), 0);
    chk("E_addr", int'(mem_addr), 0);
    chk("E_vld", int'(pix_valid), 0);
    chk("E_pix", int'(pix_out), 0);
    chk("E_done", int'(done), 0);
    snap();
    repeat (30) step();
    chk("E_no_done", tot_done - s_done, 0);
    snap();
    start_frame(3'd1);
    chk("E2_addr0", int'(mem_addr), 0);
    wait_end("E2", 784, 576, 786);

    snap();
    start_frame(3'd7);
    wait_end("F7", 1024, 784, 1026);
    snap();
    start_frame(3'd6);
    wait_end("F6", 100, 36, 102);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
